// File: rtl/mul_ctrl_pkg.sv
// Shared constants for the multiplier arbiter/sequencer.
// State encodings and default sizing.
package mul_ctrl_pkg;

  localparam int unsigned N_DEF     = 4;
  localparam int unsigned WIDTH_DEF = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_MULT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD_A = ST_LOAD_A,
    LOAD_B = ST_LOAD_B,
    MULT   = ST_MULT,
    DONE   = ST_DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request
// at or after ptr, wrapping around N clients.
module rr_arbiter
  import mul_ctrl_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    int j;
    logic [IW-1:0] jj;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    jj        = '0;
    // Walk offsets high to low so the nearest one wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (req[jj]) begin
        gnt_valid = 1'b1;
        gnt_idx   = jj;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter_ctrl.sv
// Round-robin sequencer for the shared repeated-addition multiplier.
// MUL_SWAP_EN: put the smaller operand in the B counter.
module mul_arbiter_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int IW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] op_a,
  input  logic [N*WIDTH-1:0] op_b,
  output logic [N-1:0]       ack,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic [IW-1:0]      grant_id,
  output logic               lda,
  output logic               ldb,
  output logic               ldp,
  output logic               clrp,
  output logic               decb,
  output logic [WIDTH-1:0]   data_out,
  input  logic               eqz,
  input  logic [WIDTH-1:0]   p_in
);

  state_t            state_q;
  logic [IW-1:0]     gid_q;
  logic [IW-1:0]     ptr_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  res_q;

  logic              gnt_valid;
  logic [IW-1:0]     gnt_idx;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic              swap;
  logic [WIDTH-1:0]  a_d;
  logic [WIDTH-1:0]  b_d;
  logic [IW-1:0]     ptr_d;

  rr_arbiter #(.N(N)) u_rr (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign sel_a = op_a[gnt_idx*WIDTH +: WIDTH];
  assign sel_b = op_b[gnt_idx*WIDTH +: WIDTH];

`ifdef MUL_SWAP_EN
  assign swap = sel_b > sel_a;
`else
  assign swap = 1'b0;
`endif

  assign a_d   = swap ? sel_b : sel_a;
  assign b_d   = swap ? sel_a : sel_b;
  assign ptr_d = (gid_q == IW'(N - 1)) ? '0 : gid_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gid_q   <= '0;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            gid_q   <= gnt_idx;
            a_q     <= a_d;
            b_q     <= b_d;
            state_q <= LOAD_A;
          end
        end
        LOAD_A: state_q <= LOAD_B;
        LOAD_B: state_q <= MULT;
        MULT: begin
          if (eqz) begin
            res_q   <= p_in;
            state_q <= DONE;
          end
        end
        DONE: begin
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    lda      = 1'b0;
    ldb      = 1'b0;
    ldp      = 1'b0;
    clrp     = 1'b0;
    decb     = 1'b0;
    data_out = '0;
    ack      = '0;
    unique case (state_q)
      LOAD_A: begin
        lda      = 1'b1;
        data_out = a_q;
      end
      LOAD_B: begin
        ldb      = 1'b1;
        clrp     = 1'b1;
        data_out = b_q;
      end
      MULT: begin
        ldp  = ~eqz;
        decb = ~eqz;
      end
      DONE: ack[gid_q] = 1'b1;
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = gid_q;
  assign result   = res_q;

endmodule

// File: tb/tb_mul_arbiter_ctrl.sv
// Directed bench for mul_arbiter_ctrl with a behavioural
// repeated-addition datapath (A, B counter, P).
module tb_mul_arbiter_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic [N-1:0]   ack;
  logic [W-1:0]   result;
  logic           busy;
  logic [1:0]     grant_id;
  logic           lda, ldb, ldp, clrp, decb;
  logic [W-1:0]   data_out;
  logic           eqz;
  logic [W-1:0]   p_in;

  logic [W-1:0]   dA = '0;
  logic [W-1:0]   dB = '0;
  logic [W-1:0]   dP = '0;

  int vecs  = 0;
  int fails = 0;
  int op_cyc, lda_c, ldb_c, ldp_n, ldp_first, ldp_last;
  int idx;

  mul_arbiter_ctrl #(.N(N), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op_a     (op_a),
    .op_b     (op_b),
    .ack      (ack),
    .result   (result),
    .busy     (busy),
    .grant_id (grant_id),
    .lda      (lda),
    .ldb      (ldb),
    .ldp      (ldp),
    .clrp     (clrp),
    .decb     (decb),
    .data_out (data_out),
    .eqz      (eqz),
    .p_in     (p_in)
  );

  always #5 clk = ~clk;

  assign eqz  = (dB == '0);
  assign p_in = dP;

  always @(posedge clk) begin
    if (lda) dA <= data_out;
    if (ldb) dB <= data_out;
    else if (decb) dB <= dB - 1'b1;
    if (clrp) dP <= '0;
    else if (ldp) dP <= dP + dA;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int c, input int a, input int b);
    op_a[c*W +: W] = W'(a);
    op_b[c*W +: W] = W'(b);
  endtask

  // Called at a negedge while the DUT is idle: that cycle is cycle 0.
  task automatic do_op(input string tag, input int c, input int a,
                       input int b, input int exp_res);
    int ea, eb;
    ea = a;
    eb = b;
`ifdef MUL_SWAP_EN
    if (b > a) begin
      ea = b;
      eb = a;
    end
`endif
    set_ops(c, a, b);
    req[c]    = 1'b1;
    op_cyc    = 0;
    lda_c     = 0;
    ldb_c     = 0;
    ldp_n     = 0;
    ldp_first = 0;
    ldp_last  = 0;
    while (op_cyc < 1100) begin
      @(negedge clk);
      op_cyc++;
      if (op_cyc == 1) begin
        chk({tag, "_dout_a"}, data_out, ea);
        set_ops(c, a ^ 16'h5a5a, b ^ 16'h0f0f);
      end
      if (op_cyc == 2) chk({tag, "_dout_b"}, data_out, eb);
      if (lda) lda_c = op_cyc;
      if (ldb && clrp) ldb_c = op_cyc;
      if (ldp && decb) begin
        ldp_n++;
        if (ldp_first == 0) ldp_first = op_cyc;
        ldp_last = op_cyc;
      end
      if (ack != '0) break;
    end
    chk({tag, "_ack"}, ack, 64'(1) << c);
    chk({tag, "_lat"}, op_cyc, eb + 4);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_grant"}, grant_id, c);
    req[c] = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_once"}, ack, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hold"}, result, exp_res);
  endtask

  task automatic wait_ack(output int who);
    int n;
    n   = 0;
    who = -1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (ack != '0) begin
        for (int k = 0; k < N; k++) if (ack[k]) who = k;
        break;
      end
    end
  endtask

  initial begin
    logic [N-1:0] acc;
    rst  = 1'b1;
    req  = '0;
    op_a = '0;
    op_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_result", result, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_ctrl", {lda, ldb, ldp, clrp, decb}, 0);
    chk("rst_dout", data_out, 0);
    rst = 1'b0;

    // T1: client 0, 17*5
    do_op("t1", 0, 17, 5, 85);
    chk("t1_cycle", op_cyc, 9);
    chk("t1_lda_cyc", lda_c, 1);
    chk("t1_ldb_cyc", ldb_c, 2);
    chk("t1_ldp_n", ldp_n, 5);
    chk("t1_ldp_first", ldp_first, 3);
    chk("t1_ldp_last", ldp_last, 7);

    // T2: client 1, multiplier zero
    do_op("t2", 1, 7, 0, 0);
    chk("t2_cycle", op_cyc, 4);
    chk("t2_ldp_n", ldp_n, 0);

    // T3: truncation, client 3 brings the pointer back to 0
    do_op("t3", 3, 300, 300, 24464);
    chk("t3_cycle", op_cyc, 304);

    // T4: fairness
    for (int i = 0; i < N; i++) set_ops(i, i + 2, i + 1);
    req = 4'b0101;
    wait_ack(idx);
    chk("t4a_first", idx, 0);
    chk("t4a_res0", result, 2);
    req[0] = 1'b0;
    wait_ack(idx);
    chk("t4a_second", idx, 2);
    chk("t4a_res2", result, 12);
    req = 4'b1111;
    wait_ack(idx);
    chk("t4b_g0", idx, 3);
    chk("t4b_res3", result, 20);
    wait_ack(idx);
    chk("t4b_g1", idx, 0);
    wait_ack(idx);
    chk("t4b_g2", idx, 1);
    chk("t4b_res1", result, 6);
    wait_ack(idx);
    chk("t4b_g3", idx, 2);
    wait_ack(idx);
    chk("t4b_g4", idx, 3);
    req = '0;
    @(negedge clk);
    chk("t4_idle", busy, 0);

    // T5: reset during MULT aborts without ack
    set_ops(0, 17, 5);
    req[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_busy_mult", busy, 1);
    rst    = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_ctrl", {lda, ldb, ldp, clrp, decb}, 0);
    chk("t5_ack", ack, 0);
    chk("t5_busy", busy, 0);
    chk("t5_dout", data_out, 0);
    acc = '0;
    repeat (12) begin
      @(negedge clk);
      acc = acc | ack;
    end
    chk("t5_no_ack", acc, 0);
    do_op("t5r", 0, 17, 5, 85);
    chk("t5r_cycle", op_cyc, 9);

    // T6: operand order
    do_op("t6", 2, 3, 1000, 3000);
`ifdef MUL_SWAP_EN
    chk("t6_cycle", op_cyc, 7);
`else
    chk("t6_cycle", op_cyc, 1004);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
